// File: rtl/pl_bus_regs_pkg.sv
// Shared register-map constants for the pl_bus_regs local-bus register block.
package pl_bus_regs_pkg;

  localparam logic [15:0] ADDR_ID      = 16'h0000;
  localparam logic [15:0] ADDR_SCRATCH = 16'h0001;
  localparam logic [15:0] ADDR_LED     = 16'h0002;
  localparam logic [15:0] ADDR_CNT_LO  = 16'h0003;
  localparam logic [15:0] ADDR_CNT_HI  = 16'h0004;
  localparam logic [15:0] ADDR_CTRL    = 16'h0005;

  localparam int unsigned CTRL_CLR   = 0;
  localparam int unsigned CTRL_EN    = 1;
  localparam int unsigned CTRL_BLINK = 2;

  localparam logic [15:0] DEFAULT_ID = 16'hBEEF;
  localparam logic [15:0] CTRL_RESET = 16'h0002;

endpackage

// File: rtl/pl_cycle_counter.sv
// 32-bit free-running cycle counter with clear, enable and a high-half snapshot
// latched when software reads the low half.
module pl_cycle_counter #(
  parameter int unsigned TAP_BIT = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic        snap,
  output logic [15:0] count_lo,
  output logic [15:0] snap_hi,
  output logic        tap
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      snap_hi <= '0;
    end else begin
      if (clr)
        count <= '0;
      else if (en)
        count <= count + 32'd1;
      // Snapshot uses the pre-edge value so it pairs with the low half read this cycle.
      if (snap)
        snap_hi <= count[31:16];
    end
  end

  assign count_lo = count[15:0];
  assign tap      = count[TAP_BIT];

endmodule

// File: rtl/pl_bus_regs.sv
// Local-bus register block: ID, scratch, LED, cycle counter and control.
// Optional LED blink mode is enabled by defining LED_BLINK_EN.
module pl_bus_regs
  import pl_bus_regs_pkg::*;
#(
  parameter logic [15:0] ID_VALUE  = DEFAULT_ID,
  parameter int unsigned BLINK_BIT = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] baddr,
  input  logic [15:0] bwrdata,
  output logic [15:0] brddata,
  input  logic        bwr,
  input  logic        bstrobe,
  output logic [7:0]  led
);

  logic [15:0] scratch;
  logic [7:0]  led_reg;
  logic        ctrl_en;
  logic        ctrl_blink;
  logic        wr;
  logic        rd;
  logic        clr;
  logic        snap;
  logic [15:0] count_lo;
  logic [15:0] snap_hi;
  logic        tap;

  assign wr   = bstrobe & bwr;
  assign rd   = bstrobe & ~bwr;
  assign clr  = wr && (baddr == ADDR_CTRL) && bwrdata[CTRL_CLR];
  assign snap = rd && (baddr == ADDR_CNT_LO);

  always_ff @(posedge clk) begin
    if (reset) begin
      scratch <= '0;
      led_reg <= '0;
      ctrl_en <= CTRL_RESET[CTRL_EN];
    end else if (wr) begin
      case (baddr)
        ADDR_SCRATCH: scratch <= bwrdata;
        ADDR_LED:     led_reg <= bwrdata[7:0];
        ADDR_CTRL:    ctrl_en <= bwrdata[CTRL_EN];
        default:      ;
      endcase
    end
  end

`ifdef LED_BLINK_EN
  always_ff @(posedge clk) begin
    if (reset)
      ctrl_blink <= CTRL_RESET[CTRL_BLINK];
    else if (wr && (baddr == ADDR_CTRL))
      ctrl_blink <= bwrdata[CTRL_BLINK];
  end
`else
  assign ctrl_blink = 1'b0;
`endif

  pl_cycle_counter #(
    .TAP_BIT(BLINK_BIT)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (ctrl_en),
    .clr      (clr),
    .snap     (snap),
    .count_lo (count_lo),
    .snap_hi  (snap_hi),
    .tap      (tap)
  );

  always_comb begin
    brddata = '0;
    case (baddr)
      ADDR_ID:      brddata = ID_VALUE;
      ADDR_SCRATCH: brddata = scratch;
      ADDR_LED:     brddata[7:0] = led_reg;
      ADDR_CNT_LO:  brddata = count_lo;
      ADDR_CNT_HI:  brddata = snap_hi;
      ADDR_CTRL: begin
        brddata[CTRL_EN]    = ctrl_en;
        brddata[CTRL_BLINK] = ctrl_blink;
      end
      default:      brddata = '0;
    endcase
  end

  // CLR is a write-only pulse and never reads back; blink is constant 0 when the option is absent.
  assign led = ctrl_blink ? (led_reg & {8{tap}}) : led_reg;

endmodule

// File: tb/tb_pl_bus_regs.sv
// Self-checking bench for pl_bus_regs: constant vector table, directed counter
// sequences, and randomized traffic against a behavioural register-map model.
module tb_pl_bus_regs;

  localparam logic [15:0] ID       = 16'hBEEF;
  localparam int unsigned BLINK_TB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baddr;
  logic [15:0] bwrdata;
  logic [15:0] brddata;
  logic        bwr;
  logic        bstrobe;
  logic [7:0]  led;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pl_bus_regs #(
    .ID_VALUE  (ID),
    .BLINK_BIT (BLINK_TB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .baddr   (baddr),
    .bwrdata (bwrdata),
    .brddata (brddata),
    .bwr     (bwr),
    .bstrobe (bstrobe),
    .led     (led)
  );

  // Behavioural model of the register map.
  logic [15:0] m_scratch;
  logic [7:0]  m_led;
  logic        m_en;
  logic        m_blink;
  logic [31:0] m_cnt;
  logic [15:0] m_snap;

  function automatic logic [15:0] m_read(input logic [15:0] a);
    case (a)
      16'h0000: return ID;
      16'h0001: return m_scratch;
      16'h0002: return {8'h00, m_led};
      16'h0003: return m_cnt[15:0];
      16'h0004: return m_snap;
      16'h0005: return {13'b0, m_blink, m_en, 1'b0};
      default:  return 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] m_led_out();
    if (m_blink && !m_cnt[BLINK_TB]) return 8'h00;
    return m_led;
  endfunction

  task automatic model_edge(input logic rst, input logic strb, input logic w,
                            input logic [15:0] a, input logic [15:0] d);
    logic [31:0] nc;
    if (rst) begin
      m_scratch = 16'h0000;
      m_led     = 8'h00;
      m_en      = 1'b1;
      m_blink   = 1'b0;
      m_cnt     = 32'h0;
      m_snap    = 16'h0000;
      return;
    end
    nc = m_cnt;
    if (strb && w && a == 16'h0005 && d[0]) nc = 32'h0;
    else if (m_en) nc = m_cnt + 32'd1;
    if (strb && !w && a == 16'h0003) m_snap = m_cnt[31:16];
    if (strb && w) begin
      case (a)
        16'h0001: m_scratch = d;
        16'h0002: m_led = d[7:0];
        16'h0005: begin
          m_en = d[1];
`ifdef LED_BLINK_EN
          m_blink = d[2];
`endif
        end
        default: ;
      endcase
    end
    m_cnt = nc;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, sample DUT and model before the edge, then advance the model.
  task automatic cyc(input logic rst, input logic strb, input logic w,
                     input logic [15:0] a, input logic [15:0] d,
                     output logic [15:0] rd_s, output logic [7:0] led_s,
                     output logic [15:0] exp_rd, output logic [7:0] exp_led);
    reset = rst; bstrobe = strb; bwr = w; baddr = a; bwrdata = d;
    @(negedge clk);
    rd_s = brddata; led_s = led;
    exp_rd = m_read(a); exp_led = m_led_out();
    @(posedge clk);
    model_edge(rst, strb, w, a, d);
    #1;
  endtask

  task automatic chk_cyc(input string name, input logic strb, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
    logic [15:0] r, er;
    logic [7:0]  l, el;
    cyc(1'b0, strb, w, a, d, r, l, er, el);
    check({name, "_rd"}, r, er);
    check({name, "_led"}, {8'h00, l}, {8'h00, el});
  endtask

  task automatic idle(input int n);
    logic [15:0] r, er;
    logic [7:0]  l, el;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, r, l, er, el);
  endtask

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_rd;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mkv(input logic w, input logic [15:0] a, input logic [15:0] d,
                               input logic [15:0] e, input logic [7:0] el);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.exp_rd = e; v.exp_led = el;
    return v;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] r, er, lo, hi, lo2;
    logic [7:0]  l, el;
    logic [31:0] exp_cnt;
    bit seen_on, seen_off;

    vecs[0]  = mkv(1'b0, 16'h0000, 16'h0000, 16'hBEEF, 8'h00);
    vecs[1]  = mkv(1'b0, 16'h0001, 16'h0000, 16'h0000, 8'h00);
    vecs[2]  = mkv(1'b1, 16'h0001, 16'h1234, 16'h0000, 8'h00);
    vecs[3]  = mkv(1'b0, 16'h0001, 16'h0000, 16'h1234, 8'h00);
    vecs[4]  = mkv(1'b0, 16'h0009, 16'h0000, 16'h0000, 8'h00);
    vecs[5]  = mkv(1'b1, 16'h0002, 16'h12A5, 16'h0000, 8'h00);
    vecs[6]  = mkv(1'b0, 16'h0002, 16'h0000, 16'h00A5, 8'hA5);
    vecs[7]  = mkv(1'b1, 16'h0000, 16'hFFFF, 16'h0000, 8'hA5);
    vecs[8]  = mkv(1'b0, 16'h0000, 16'h0000, 16'hBEEF, 8'hA5);
    vecs[9]  = mkv(1'b1, 16'h0009, 16'h5555, 16'h0000, 8'hA5);
    vecs[10] = mkv(1'b0, 16'h0009, 16'h0000, 16'h0000, 8'hA5);
    vecs[11] = mkv(1'b0, 16'h0005, 16'h0000, 16'h0002, 8'hA5);
    vecs[12] = mkv(1'b1, 16'h0002, 16'hFF3C, 16'h0000, 8'hA5);
    vecs[13] = mkv(1'b0, 16'h0002, 16'h0000, 16'h003C, 8'h3C);

    reset = 1'b1; bstrobe = 1'b0; bwr = 1'b0; baddr = '0; bwrdata = '0;
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, r, l, er, el);
    cyc(1'b1, 1'b1, 1'b1, 16'h0001, 16'hABCD, r, l, er, el);
    cyc(1'b1, 1'b1, 1'b1, 16'h0002, 16'h00FF, r, l, er, el);

    // Constant-vector table; reset-with-write above must have been ignored.
    foreach (vecs[i]) begin
      cyc(1'b0, 1'b1, vecs[i].w, vecs[i].a, vecs[i].d, r, l, er, el);
      if (!vecs[i].w) check($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
      check($sformatf("vec%0d_led", i), {8'h00, l}, {8'h00, vecs[i].exp_led});
    end

    // Clear with enable kept on.
    idle(100);
    chk_cyc("clr_wr", 1'b1, 1'b1, 16'h0005, 16'h0003);
    cyc(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, r, l, er, el);
    check("clr_lo", r, er);
    check("clr_lo_small", {15'b0, r < 16'h0010}, 16'h0001);
    cyc(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, r, l, er, el);
    check("clr_hi", r, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, r, l, er, el);
    check("clr_ctrl", r, 16'h0002);

    // Counter frozen.
    chk_cyc("dis_wr", 1'b1, 1'b1, 16'h0005, 16'h0000);
    idle(3);
    cyc(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, r, l, er, el);
    lo = r;
    check("dis_lo1", r, er);
    idle(5);
    cyc(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, r, l, er, el);
    check("dis_lo2", r, lo);
    chk_cyc("dis_ctrl", 1'b1, 1'b0, 16'h0005, 16'h0000);

    // Snapshot consistency across the 16-bit carry.
    chk_cyc("carry_clr", 1'b1, 1'b1, 16'h0005, 16'h0003);
    idle(65500);
    hi = '0;
    for (int i = 0; i < 40; i++) begin
      exp_cnt = m_cnt;
      cyc(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, r, l, er, el);
      lo2 = r;
      cyc(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, r, l, er, el);
      hi = r;
      check($sformatf("carry_pair%0d_lo", i), lo2, exp_cnt[15:0]);
      check($sformatf("carry_pair%0d_hi", i), hi, exp_cnt[31:16]);
    end
    check("carry_hi_final", hi, 16'h0001);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      chk_cyc("rand", $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              16'($urandom_range(0, 7)), 16'($urandom));
    end

    // Blink control.
    chk_cyc("blk_led", 1'b1, 1'b1, 16'h0002, 16'h00FF);
    chk_cyc("blk_ctrl", 1'b1, 1'b1, 16'h0005, 16'h0006);
    cyc(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, r, l, er, el);
`ifdef LED_BLINK_EN
    check("blk_ctrl_rd", r, 16'h0006);
`else
    check("blk_ctrl_rd", r, 16'h0002);
`endif
    seen_on = 0; seen_off = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, r, l, er, el);
      check("blk_led_out", {8'h00, l}, {8'h00, el});
      if (l == 8'hFF) seen_on = 1;
      if (l == 8'h00) seen_off = 1;
    end
`ifdef LED_BLINK_EN
    check("blk_toggles", {14'b0, seen_on, seen_off}, 16'h0003);
`else
    check("blk_steady", {14'b0, seen_on, seen_off}, 16'h0002);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
